// File: rtl/i2s_audio_tx.sv
// i2s_audio_tx: Philips I2S transmitter with sample FIFO, volume and mono mix; `I2S_TX_HOLD_ON_UNDERRUN_EN repeats the last frame on underrun
module i2s_audio_tx #(
    parameter int SAMPLE_W   = 16,
    parameter int SLOT_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DIV_W-1:0]              bclk_div,
    input  logic [1:0]                    volume,
    input  logic                          mono_mix,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SAMPLE_W-1:0]           in_left,
    input  logic [SAMPLE_W-1:0]           in_right,
    output logic                          i2s_bck,
    output logic                          i2s_ws,
    output logic                          i2s_din,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int FW = 2 * SLOT_W;
    localparam int KW = $clog2(FW);

    logic [2*SAMPLE_W-1:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]                wr_ptr, rd_ptr;
    logic [DIV_W-1:0]             cnt;
    logic [KW-1:0]                k, k_new, idx;
    logic [FW-1:0]                f, f_next, frame;
    logic signed [SAMPLE_W-1:0]   hl, hr, al, ar;
    logic [SAMPLE_W-1:0]          mix, ml, mr;
    logic                         live, wrap, fall, load, empty, push, pop;
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
    logic [FW-1:0]                held;
`endif

    function automatic logic [SAMPLE_W-1:0] scale(input logic signed [SAMPLE_W-1:0] x, input logic [1:0] v);
        logic signed [SAMPLE_W-1:0] q2, q1;
        q2 = x >>> 2;
        q1 = x >>> 1;
        return v == 2'd0 ? '0 : v == 2'd1 ? q2 : v == 2'd2 ? q1 : x;
    endfunction

    function automatic logic [SLOT_W-1:0] slot(input logic [SAMPLE_W-1:0] x);
        logic [SLOT_W-1:0] s;
        s = SLOT_W'(x);
        return s << (SLOT_W - SAMPLE_W);
    endfunction

    always_comb begin
        empty    = fifo_level == '0;
        in_ready = live && !reset && fifo_level < LW'(FIFO_DEPTH);
        push     = in_valid && in_ready;
        wrap     = cnt >= bclk_div;
        fall     = wrap && i2s_bck;
        k_new    = k == KW'(FW - 1) ? '0 : k + KW'(1);
        load     = fall && k_new == KW'(1);
        pop      = load && !empty;
        {hl, hr} = mem[rd_ptr];
        // floor((L+R)/2) without a wider intermediate: halves plus the shared carry
        al       = hl >>> 1;
        ar       = hr >>> 1;
        mix      = al + ar + SAMPLE_W'(hl[0] & hr[0]);
        ml       = mono_mix ? mix : hl;
        mr       = mono_mix ? mix : hr;
        frame    = {slot(scale(ml, volume)), slot(scale(mr, volume))};
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
        f_next   = load ? (empty ? held : frame) : f;
`else
        f_next   = load ? (empty ? '0 : frame) : f;
`endif
        idx      = k_new == '0 ? '0 : KW'(FW - int'(k_new));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            live       <= 1'b0;
            cnt        <= '0;
            i2s_bck    <= 1'b0;
            i2s_ws     <= 1'b0;
            i2s_din    <= 1'b0;
            underrun   <= 1'b0;
            k          <= '0;
            f          <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
            held       <= '0;
`endif
        end else begin
            live       <= 1'b1;
            cnt        <= wrap ? '0 : cnt + DIV_W'(1);
            i2s_bck    <= wrap ? ~i2s_bck : i2s_bck;
            underrun   <= load && empty;
            f          <= f_next;
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
            if (fall) begin
                k       <= k_new;
                i2s_ws  <= k_new >= KW'(SLOT_W);
                i2s_din <= f_next[idx];
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
            if (pop) held <= frame;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_left, in_right};
    end
endmodule
